divi_pipe_param: RTL

//  Parametrised pipelined restoring divider, NUM_W-bit dividend by DEN_W-bit divisor, one quotient bit per step.
//  Per-transaction signed/unsigned mode, divide-by-zero and signed-overflow flags, opaque tag pass-through.

---
 rtl/divi_pkg.sv | 35 +++
 rtl/divi_step_chain.sv | 32 +++
 rtl/divi_pipe_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/divi_pkg.sv
// Shared helpers and rank control fields for the pipelined restoring divider.
package divi_pkg;

  typedef struct packed {
    logic valid;
    logic sgn_q;
    logic sgn_r;
    logic div0;
    logic ovf;
  } rank_ctl_t;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int bps(input int num_w, input int stages);
    return ceil_div(num_w, stages);
  endfunction

  // Quotient bits handled by compute rank k; the last rank takes what is left.
  function automatic int rank_bits(input int num_w, input int stages, input int k);
    int per_rank = bps(num_w, stages);
    int left     = num_w - k * per_rank;
    if (left <= 0)        return 0;
    if (k == stages - 1)  return left;
    return (left < per_rank) ? left : per_rank;
  endfunction

endpackage

// File: rtl/divi_step_chain.sv
// Combinational chain of NBITS restoring divide steps, dividend bits consumed MSB first.
module divi_step_chain #(
  parameter int DEN_W = 24,
  parameter int NBITS = 6
) (
  input  logic [DEN_W-1:0] rem_in,
  input  logic [NBITS-1:0] num_bits_in,
  input  logic [DEN_W-1:0] den,
  output logic [DEN_W-1:0] rem_out,
  output logic [NBITS-1:0] q_bits
);

  logic [DEN_W:0]   trial;
  logic [DEN_W-1:0] part;

  // NOTE: blocking assignments here model a ripple of steps within one cycle.
  always_comb begin
    trial  = '0;
    part   = rem_in;
    q_bits = '0;
    for (int i = NBITS - 1; i >= 0; i--) begin
      trial = {part, num_bits_in[i]};
      if (trial >= {1'b0, den}) begin
        q_bits[i] = 1'b1;
        trial     = trial - {1'b0, den};
      end
      part = trial[DEN_W-1:0];
    end
    rem_out = part;
  end

endmodule

// File: rtl/divi_pipe_param.sv
// Pipelined restoring divider: capture/abs rank, STAGES compute ranks, sign fix-up in the output rank.
module divi_pipe_param
  import divi_pkg::*;
#(
  parameter int NUM_W  = 48,
  parameter int DEN_W  = 24,
  parameter int STAGES = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sgn,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NUM_W-1:0] out_quo,
  output logic [DEN_W-1:0] out_rem,
  output logic             out_div0,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    rank_ctl_t        ctl;
    logic [TAG_W-1:0] tag;
    logic [DEN_W-1:0] den;
    logic [DEN_W-1:0] rem;
    logic [NUM_W-1:0] num;
    logic [NUM_W-1:0] quo;
  } rank_t;

  localparam logic [NUM_W-1:0] NUM_MIN = {1'b1, {(NUM_W-1){1'b0}}};
  localparam int               LAST    = STAGES - 1;

  logic             adv;
  logic             num_neg, den_neg;
  rank_t            cap_d, cap_q;
  rank_t            stage_w [STAGES];
  rank_t            step_w  [STAGES];
  logic [NUM_W-1:0] quo_d;
  logic [DEN_W-1:0] rem_d;
  logic             out_valid_q, out_div0_q, out_ovf_q;
  logic [NUM_W-1:0] out_quo_q;
  logic [DEN_W-1:0] out_rem_q;
  logic [TAG_W-1:0] out_tag_q;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv & ~rst;

  assign num_neg = in_sgn & in_num[NUM_W-1];
  assign den_neg = in_sgn & in_den[DEN_W-1];

  always_comb begin
    cap_d           = '0;
    cap_d.ctl.valid = in_valid;
    cap_d.ctl.sgn_q = num_neg ^ den_neg;
    cap_d.ctl.sgn_r = num_neg;
    cap_d.ctl.div0  = (in_den == '0);
    cap_d.ctl.ovf   = in_sgn & (in_num == NUM_MIN) & (in_den == '1);
    cap_d.tag       = in_tag;
    cap_d.den       = den_neg ? -in_den : in_den;
    cap_d.num       = num_neg ? -in_num : in_num;
  end

  // NOTE: only valid bits are reset; data ranks are don't-care while their valid is low.
  always_ff @(posedge clk) begin
    if (rst)      cap_q.ctl.valid <= 1'b0;
    else if (adv) cap_q           <= cap_d;
  end

  assign stage_w[0] = cap_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_rank
    localparam int NB = rank_bits(NUM_W, STAGES, k);
    logic [DEN_W-1:0] rem_w;
    logic [NUM_W-1:0] num_w, quo_w;

    if (NB > 0) begin : g_step
      logic [NB-1:0] qb;
      divi_step_chain #(.DEN_W(DEN_W), .NBITS(NB)) u_chain (
        .rem_in      (stage_w[k].rem),
        .num_bits_in (stage_w[k].num[NUM_W-1 -: NB]),
        .den         (stage_w[k].den),
        .rem_out     (rem_w),
        .q_bits      (qb)
      );
      assign num_w = stage_w[k].num << NB;
      assign quo_w = (stage_w[k].quo << NB) | NUM_W'(qb);
    end else begin : g_pass
      assign rem_w = stage_w[k].rem;
      assign num_w = stage_w[k].num;
      assign quo_w = stage_w[k].quo;
    end

    assign step_w[k] = '{ctl: stage_w[k].ctl, tag: stage_w[k].tag, den: stage_w[k].den,
                         rem: rem_w, num: num_w, quo: quo_w};

    if (k < LAST) begin : g_reg
      rank_t r_q;
      always_ff @(posedge clk) begin
        if (rst)      r_q.ctl.valid <= 1'b0;
        else if (adv) r_q           <= step_w[k];
      end
      assign stage_w[k+1] = r_q;
    end
  end

  // Magnitudes back to signed form: quotient truncates toward zero, remainder follows the dividend.
  always_comb begin
    quo_d = step_w[LAST].ctl.sgn_q ? -step_w[LAST].quo : step_w[LAST].quo;
    rem_d = step_w[LAST].ctl.sgn_r ? -step_w[LAST].rem : step_w[LAST].rem;
    if (step_w[LAST].ctl.div0) begin
      quo_d = '0;
      rem_d = '0;
    end else if (step_w[LAST].ctl.ovf) begin
      quo_d = NUM_MIN;
      rem_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_div0_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
    end else if (adv) begin
      out_valid_q <= step_w[LAST].ctl.valid;
      if (step_w[LAST].ctl.valid) begin
        out_quo_q  <= quo_d;
        out_rem_q  <= rem_d;
        out_div0_q <= step_w[LAST].ctl.div0;
        out_ovf_q  <= step_w[LAST].ctl.ovf;
        out_tag_q  <= step_w[LAST].tag;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_quo   = out_quo_q;
  assign out_rem   = out_rem_q;
  assign out_div0  = out_div0_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

endmodule
